// File: rtl/axi_mem_master_bridge.sv
// axi_mem_master_bridge
//   Turns one SRAM-style request (active-low write enable / bit mask) from a
//   CPU port into a single AXI4 INCR burst of mem_len+1 beats on one master
//   port. Read beats are streamed back through mem_dout/mem_rvalid. Write
//   beats are pulled from the requester through mem_din/mem_bweb, with
//   mem_wnext acknowledging each consumed beat. mem_done/mem_err close every
//   request.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_req         request strobe, only looked at while idle
//   mem_web         1 = read, 0 = write
//   mem_bweb        active-low bit write mask of the current write beat
//   mem_addr        start byte address (latched on acceptance)
//   mem_len         beats-1 (latched on acceptance)
//   mem_din         data of the current write beat
//   mem_wnext       current write beat consumed, present the next one
//   mem_dout        registered read beat data
//   mem_rvalid      one-cycle pulse per read beat
//   mem_busy        request in progress
//   mem_done        one-cycle completion pulse
//   mem_err         error flag qualified by mem_done
//   M_AW*/M_W*/M_B*/M_AR*/M_R*  AXI4 master channels
module axi_mem_master_bridge #(
  parameter int ID_VALUE = 0,
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  // requester side
  input  logic                mem_req,
  input  logic                mem_web,
  input  logic [DATA_W-1:0]   mem_bweb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [LEN_W-1:0]    mem_len,
  input  logic [DATA_W-1:0]   mem_din,
  output logic                mem_wnext,
  output logic [DATA_W-1:0]   mem_dout,
  output logic                mem_rvalid,
  output logic                mem_busy,
  output logic                mem_done,
  output logic                mem_err,
  // write address channel
  output logic [ID_W-1:0]     M_AWID,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic [7:0]          M_AWLEN,
  output logic [2:0]          M_AWSIZE,
  output logic [1:0]          M_AWBURST,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  // write data channel
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WLAST,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  // write response channel
  input  logic [ID_W-1:0]     M_BID,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  // read address channel
  output logic [ID_W-1:0]     M_ARID,
  output logic [ADDR_W-1:0]   M_ARADDR,
  output logic [7:0]          M_ARLEN,
  output logic [2:0]          M_ARSIZE,
  output logic [1:0]          M_ARBURST,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  // read data channel
  input  logic [ID_W-1:0]     M_RID,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic [1:0]          M_RRESP,
  input  logic                M_RLAST,
  input  logic                M_RVALID,
  output logic                M_RREADY
);

  localparam int                STRB_W     = DATA_W / 8;
  localparam logic [2:0]        AXI_SIZE   = 3'($clog2(STRB_W));
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  // One bit wider than the length so over-long read bursts do not alias
  // back onto a valid beat number.
  logic [LEN_W:0]     beat_cnt;
  logic               err_q;
  logic               at_len;
  logic               misaligned;
  logic               r_err;
  logic               unused_id;

  assign at_len     = (beat_cnt == {1'b0, len_q});
  assign misaligned = ((mem_addr & ALIGN_MASK) != '0);

  // Sticky error including the beat being accepted now: bad response, RLast
  // on the wrong beat, or the final beat arriving without RLast.
  assign r_err = err_q | (M_RRESP != 2'b00) | (M_RLAST ? !at_len : at_len);

  // Read/write transaction IDs are not checked; a single outstanding burst
  // cannot be confused with another one.
  assign unused_id = ^{M_BID, M_RID};

  assign M_AWID    = ID_W'(ID_VALUE);
  assign M_ARID    = ID_W'(ID_VALUE);
  assign M_AWADDR  = addr_q;
  assign M_ARADDR  = addr_q;
  assign M_AWLEN   = 8'(len_q);
  assign M_ARLEN   = 8'(len_q);
  assign M_AWSIZE  = AXI_SIZE;
  assign M_ARSIZE  = AXI_SIZE;
  assign M_AWBURST = 2'b01;
  assign M_ARBURST = 2'b01;

  // Write beats are taken straight from the requester; a byte lane is
  // enabled when any bit of it is being written.
  assign M_WDATA   = mem_din;
  assign M_WLAST   = M_WVALID & at_len;
  assign mem_wnext = M_WVALID & M_WREADY;

  for (genvar i = 0; i < STRB_W; i++) begin : g_strb
    assign M_WSTRB[i] = ~&mem_bweb[8*i +: 8];
  end

  assign mem_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
      M_ARVALID  <= 1'b0;
      M_RREADY   <= 1'b0;
      M_AWVALID  <= 1'b0;
      M_WVALID   <= 1'b0;
      M_BREADY   <= 1'b0;
      mem_dout   <= '0;
      mem_rvalid <= 1'b0;
      mem_done   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            addr_q <= mem_addr;
            len_q  <= mem_len;
            if (misaligned) begin
              // Rejected without touching the bus.
              state    <= S_DONE;
              mem_done <= 1'b1;
              mem_err  <= 1'b1;
            end else if (mem_web) begin
              state     <= S_AR;
              M_ARVALID <= 1'b1;
            end else begin
              state     <= S_AW;
              M_AWVALID <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state     <= S_R;
          end
        end
        S_R: begin
          if (M_RVALID) begin
            mem_dout   <= M_RDATA;
            mem_rvalid <= 1'b1;
            beat_cnt   <= beat_cnt + 1'b1;
            err_q      <= r_err;
            // Only RLast ends the burst, even when it comes late.
            if (M_RLAST) begin
              M_RREADY <= 1'b0;
              mem_done <= 1'b1;
              mem_err  <= r_err;
              state    <= S_DONE;
            end
          end
        end
        S_AW: begin
          if (M_AWREADY) begin
            M_AWVALID <= 1'b0;
            M_WVALID  <= 1'b1;
            state     <= S_W;
          end
        end
        S_W: begin
          if (M_WREADY) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (at_len) begin
              M_WVALID <= 1'b0;
              M_BREADY <= 1'b1;
              state    <= S_B;
            end
          end
        end
        S_B: begin
          if (M_BVALID) begin
            M_BREADY <= 1'b0;
            mem_done <= 1'b1;
            mem_err  <= err_q | (M_BRESP != 2'b00);
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          mem_done <= 1'b0;
          mem_err  <= 1'b0;
          err_q    <= 1'b0;
          beat_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_master_bridge.sv
// Testbench for axi_mem_master_bridge: a table of directed requests followed
// by randomized requests, each played against a behavioural AXI slave and
// requester, with expectations from a transaction-level model.
module tb_axi_mem_master_bridge;

  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4, IDV = 5;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req, mem_web;
  logic [DATA_W-1:0] mem_bweb, mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic [LEN_W-1:0]  mem_len;
  logic              mem_wnext, mem_rvalid, mem_busy, mem_done, mem_err;
  logic [ID_W-1:0]   M_AWID, M_ARID, M_BID, M_RID;
  logic [ADDR_W-1:0] M_AWADDR, M_ARADDR;
  logic [7:0]        M_AWLEN, M_ARLEN;
  logic [2:0]        M_AWSIZE, M_ARSIZE;
  logic [1:0]        M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
  logic              M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY;
  logic              M_BVALID, M_BREADY, M_ARVALID, M_ARREADY;
  logic              M_RLAST, M_RVALID, M_RREADY;
  logic [DATA_W-1:0] M_WDATA, M_RDATA;
  logic [3:0]        M_WSTRB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_mem_master_bridge #(.ID_VALUE(IDV), .ID_W(ID_W), .ADDR_W(ADDR_W),
                          .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_web(mem_web), .mem_bweb(mem_bweb),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_din(mem_din),
    .mem_wnext(mem_wnext), .mem_dout(mem_dout), .mem_rvalid(mem_rvalid),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
    .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID),
    .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
    .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  // One request plus slave behaviour plus expected outcome.
  typedef struct {
    logic        web;
    logic [31:0] addr;
    int          len;
    int          waits;      // slave stall cycles before each ready/valid
    int          rlast_at;   // read beat index carrying RLast
    int          resp_beat;  // read beat with non-OKAY resp (-1: none)
    logic [1:0]  resp;       // RRESP on resp_beat, or BRESP for writes
    logic [31:0] bweb;
    logic [31:0] rdata0;     // first read beat data (0: random)
    int          rst_at;     // assert rst while this write beat is offered
    logic        exp_err;
    int          exp_lat;    // cycles from acceptance to mem_done (-1: skip)
    int          exp_beats;  // rvalid pulses (read) or wnext pulses (write)
  } vec_t;

  function automatic vec_t mk(logic web, logic [31:0] addr, int len, int waits,
                              int rlast_at, int resp_beat, logic [1:0] resp,
                              logic [31:0] bweb, logic [31:0] rdata0, int rst_at,
                              logic exp_err, int exp_lat, int exp_beats);
    vec_t v;
    v.web = web; v.addr = addr; v.len = len; v.waits = waits;
    v.rlast_at = rlast_at; v.resp_beat = resp_beat; v.resp = resp;
    v.bweb = bweb; v.rdata0 = rdata0; v.rst_at = rst_at;
    v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_beats = exp_beats;
    return v;
  endfunction

  // Reference model: outcome of a request from the protocol rules alone.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    logic mis = (v.addr[1:0] != 2'b00);
    if (mis) begin
      r.exp_err = 1'b1; r.exp_beats = 0; r.exp_lat = 1;
    end else if (v.web) begin
      r.exp_err = (v.rlast_at != v.len) ||
                  (v.resp_beat >= 0 && v.resp_beat <= v.rlast_at && v.resp != 2'b00);
      r.exp_beats = v.rlast_at + 1;
      r.exp_lat = -1;
    end else begin
      r.exp_err = (v.resp != 2'b00);
      r.exp_beats = v.len + 1;
      r.exp_lat = -1;
    end
    return r;
  endfunction

  // A byte lane is written when any bit of it is enabled (active low).
  function automatic logic [3:0] strb_of(logic [31:0] bweb);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (bweb[8*i +: 8] != 8'hFF);
    return s;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic slave_idle();
    M_ARREADY = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0;
    M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00; M_RDATA = '0;
    M_BVALID = 1'b0; M_BRESP = 2'b00;
    M_RID = ID_W'(IDV); M_BID = ID_W'(IDV);
  endtask

  task automatic run_txn(input vec_t v);
    logic [31:0] exp_q[$];
    logic [31:0] cur_din, cur_rd;
    bit addr_done = 0, r_phase = 0, w_phase = 0, b_phase = 0, done_seen = 0;
    int awt = 0, dwt = 0, rbeat = 0, wbeat = 0, nrv = 0, nwn = 0, nav = 0;
    cur_din = $urandom;
    cur_rd  = (v.rdata0 != 0) ? v.rdata0 : $urandom;

    @(negedge clk);
    mem_req = 1'b1; mem_web = v.web; mem_addr = v.addr;
    mem_len = LEN_W'(v.len); mem_din = cur_din; mem_bweb = v.bweb;
    slave_idle();
    @(posedge clk);

    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      // Requester keeps poking unrelated requests; they must be ignored.
      mem_req = 1'($urandom); mem_web = 1'($urandom);
      mem_addr = $urandom; mem_len = LEN_W'($urandom);
      mem_din = cur_din; mem_bweb = v.bweb;
      slave_idle();
      if (!addr_done) begin
        if (awt >= v.waits) begin M_ARREADY = 1'b1; M_AWREADY = 1'b1; end
        awt++;
      end else if (r_phase) begin
        if (dwt >= v.waits) begin
          M_RVALID = 1'b1; M_RDATA = cur_rd;
          M_RLAST = (rbeat == v.rlast_at);
          M_RRESP = (rbeat == v.resp_beat) ? v.resp : 2'b00;
        end else dwt++;
      end else if (w_phase) begin
        if (dwt >= v.waits) M_WREADY = 1'b1; else dwt++;
      end else if (b_phase) begin
        if (dwt >= v.waits) begin M_BVALID = 1'b1; M_BRESP = v.resp; end else dwt++;
      end
      #1;
      chk("busy", mem_busy, 1);
      if (M_ARVALID) begin
        nav++;
        chk("araddr", M_ARADDR, v.addr); chk("arlen", M_ARLEN, v.len);
        chk("arsize", M_ARSIZE, 2);      chk("arburst", M_ARBURST, 1);
        chk("arid", M_ARID, IDV);        chk("ar_dir", v.web, 1);
      end
      if (M_AWVALID) begin
        nav++;
        chk("awaddr", M_AWADDR, v.addr); chk("awlen", M_AWLEN, v.len);
        chk("awsize", M_AWSIZE, 2);      chk("awburst", M_AWBURST, 1);
        chk("awid", M_AWID, IDV);        chk("aw_dir", v.web, 0);
      end
      if (M_WVALID) begin
        chk("w_after_aw", addr_done, 1);
        chk("wdata", M_WDATA, cur_din);
        chk("wstrb", M_WSTRB, strb_of(v.bweb));
        chk("wlast", M_WLAST, (wbeat == v.len));
      end
      if (mem_rvalid) begin
        nrv++;
        chk("rvalid_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("dout", mem_dout, exp_q.pop_front());
      end
      if (mem_wnext) nwn++;

      if (v.rst_at >= 0 && w_phase && M_WVALID && wbeat == v.rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wvalid", M_WVALID, 0); chk("rst_busy", mem_busy, 0);
        chk("rst_awvalid", M_AWVALID, 0); chk("rst_bready", M_BREADY, 0);
        chk("rst_done", mem_done, 0); chk("rst_wnext", mem_wnext, 0);
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0; slave_idle();
        return;
      end

      if (!addr_done && ((M_ARVALID && M_ARREADY) || (M_AWVALID && M_AWREADY))) begin
        addr_done = 1; dwt = 0;
        if (v.web) r_phase = 1; else w_phase = 1;
      end else if (r_phase && M_RVALID && M_RREADY) begin
        exp_q.push_back(M_RDATA);
        rbeat++; dwt = 0; cur_rd = $urandom;
        if (M_RLAST) r_phase = 0;
      end else if (w_phase && M_WVALID && M_WREADY) begin
        wbeat++; dwt = 0; cur_din = $urandom;
        if (wbeat == v.len + 1) begin w_phase = 0; b_phase = 1; end
      end else if (b_phase && M_BVALID && M_BREADY) begin
        b_phase = 0;
      end

      if (mem_done) begin
        done_seen = 1;
        chk("err", mem_err, v.exp_err);
        if (v.exp_lat >= 0) chk("latency", c, v.exp_lat);
        if (v.web) chk("rvalid_count", nrv, v.exp_beats);
        else       chk("wnext_count", nwn, v.exp_beats);
        chk("rdata_drained", exp_q.size(), 0);
        if (v.addr[1:0] != 2'b00) chk("no_axi_on_misalign", nav, 0);
        break;
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);

    @(negedge clk);
    mem_req = 1'b0; slave_idle();
    #1;
    chk("done_pulse", mem_done, 0);
    chk("idle_busy", mem_busy, 0);
  endtask

  vec_t tbl[12];

  initial begin
    //        web   addr          len wt rl  rb resp   bweb           rdata0        rst err lat beats
    tbl[0]  = mk(1, 32'h0000_0010, 0, 0, 0, -1, 2'b00, 32'h0,        32'hDEADBEEF, -1, 0, 3, 1);
    tbl[1]  = mk(1, 32'h0000_0100, 3, 2, 3, -1, 2'b00, 32'h0,        32'h0,        -1, 0, -1, 4);
    tbl[2]  = mk(0, 32'h0000_0200, 1, 0, 0, -1, 2'b00, 32'hFFFF_00FF, 32'h0,       -1, 0, 5, 2);
    tbl[3]  = mk(0, 32'h0000_0300, 0, 0, 0, -1, 2'b10, 32'h0,        32'h0,        -1, 1, 4, 1);
    tbl[4]  = mk(1, 32'h0000_0400, 0, 0, 0, -1, 2'b00, 32'h0,        32'h1234_5678, -1, 0, 3, 1);
    tbl[5]  = mk(1, 32'h0000_0002, 0, 0, 0, -1, 2'b00, 32'h0,        32'h0,        -1, 1, 1, 0);
    tbl[6]  = mk(0, 32'h0000_0006, 2, 0, 0, -1, 2'b00, 32'h0,        32'h0,        -1, 1, 1, 0);
    tbl[7]  = mk(1, 32'h0000_0500, 2, 1, 2, 1,  2'b10, 32'h0,        32'h0,        -1, 1, -1, 3);
    tbl[8]  = mk(1, 32'h0000_0600, 2, 0, 1, -1, 2'b00, 32'h0,        32'h0,        -1, 1, -1, 2);
    tbl[9]  = mk(1, 32'h0000_0700, 1, 0, 2, -1, 2'b00, 32'h0,        32'h0,        -1, 1, -1, 3);
    tbl[10] = mk(0, 32'h0000_0800, 3, 0, 0, -1, 2'b00, 32'h00FF_0000, 32'h0,       1,  0, -1, 4);
    tbl[11] = mk(1, 32'h0000_0900, 0, 0, 0, -1, 2'b00, 32'h0,        32'hCAFE_F00D, -1, 0, 3, 1);

    // Reset with noisy inputs: every output must come up at its reset value.
    rst = 1'b1; mem_req = 1'b1; mem_web = 1'b1; mem_addr = 32'h40;
    mem_len = '0; mem_din = '0; mem_bweb = '1; slave_idle();
    M_ARREADY = 1'b1; M_RVALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", M_ARVALID, 0); chk("rst_rready", M_RREADY, 0);
    chk("rst_awvalid0", M_AWVALID, 0); chk("rst_wvalid0", M_WVALID, 0);
    chk("rst_bready0", M_BREADY, 0);   chk("rst_busy0", mem_busy, 0);
    chk("rst_done0", mem_done, 0);     chk("rst_err0", mem_err, 0);
    chk("rst_rvalid0", mem_rvalid, 0); chk("rst_dout0", mem_dout, 0);
    chk("rst_araddr0", M_ARADDR, 0);   chk("rst_arlen0", M_ARLEN, 0);
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0; slave_idle();

    for (int i = 0; i < 12; i++) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.web = 1'($urandom);
      v.len = $urandom_range(0, 7);
      v.addr = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
      v.waits = $urandom_range(0, 2);
      v.rlast_at = v.len;
      if ($urandom_range(0, 3) == 0)
        v.rlast_at = (v.len > 0 && $urandom_range(0, 1) == 1) ? v.len - 1 : v.len + 1;
      v.resp_beat = ($urandom_range(0, 1) == 1) ? $urandom_range(0, v.rlast_at) : -1;
      v.resp = 2'($urandom);
      if (!v.web && $urandom_range(0, 1) == 1) v.resp = 2'b00;
      v.bweb = $urandom;
      v.rdata0 = 32'h0;
      v.rst_at = -1;
      run_txn(model(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_mem_master_bridge.md
# axi_mem_master_bridge

Parametrised successor to the single-beat memory-to-AXI master adapter used behind each CPU port (instruction fetch, data access). It accepts one SRAM-style request at a time from the core (active-low WEB/BWEB, address, data) and turns it into an AXI4 INCR burst of 1..2^LEN_W beats on one master port. Read beats and write-data requests are streamed back to the requester, and busy/done/error status is reported. The CPU wrapper instantiates one bridge per master (M0 = IM, M1 = DM) with its own ID_VALUE.

## Interface
- ID_VALUE, 0: constant driven on M_AWID/M_ARID.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; multiple of 8, power of two.
- LEN_W, 4: burst length field width (beats = mem_len+1).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  in  1  request strobe; sampled only in IDLE.
- mem_web  in  1  0 = write, 1 = read.
- mem_bweb  in  DATA_W  active-low bit write mask, live per write beat.
- mem_addr  in  ADDR_W  start byte address, latched on acceptance.
- mem_len  in  LEN_W  beats-1, latched on acceptance.
- mem_din  in  DATA_W  write data, live per write beat.
- mem_wnext  out  1  pulse: the current mem_din/mem_bweb was consumed; present the next beat.
- mem_dout  out  DATA_W  registered read beat data.
- mem_rvalid  out  1  one-cycle pulse per read beat.
- mem_busy  out  1  high in every state except IDLE.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  valid with mem_done; 1 = SLVERR/DECERR, RLast mismatch, or misaligned address.
- M_AW*: ID, Addr, Len, Size, Burst, Valid out, Ready in.
- M_W*: Data, Strb, Last, Valid out, Ready in.
- M_B*: ID, Resp, Valid in, Ready out.
- M_AR*: ID, Addr, Len, Size, Burst, Valid out, Ready in.
- M_R*: ID, Data, Resp, Last, Valid in, Ready out.

## Operation
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE & mem_req: latch addr, len, web; go to AR (web=1) or AW (web=0).
- Misaligned address (addr[log2(DATA_W/8)-1:0] != 0): go directly to DONE with err=1; no AXI traffic.
- AR: ARValid=1; Addr/Len latched; Size=log2(DATA_W/8); Burst=2'b01. On ARReady go to R.
- R: RReady=1. Each RValid beat: mem_dout<=RData, mem_rvalid pulse next cycle, beat counter++, err|=(RResp!=0). On RLast go to DONE; err|=(counter!=len). A beat with counter==len and no RLast also sets err, and the FSM keeps waiting for RLast.
- AW: AWValid=1. On AWReady go to W. W never starts before the AW handshake.
- W: WValid=1; WData=mem_din; WStrb[i]=~&mem_bweb[8i+7:8i]; WLast=(counter==len). mem_wnext=WValid&WReady, combinational. On the handshake counter++; on the last beat go to B.
- B: BReady=1. On BValid, err|=(BResp!=0), then go to DONE.
- DONE: mem_done=1 and mem_err for one cycle, clear err/counter, go to IDLE. A new request is accepted in the cycle after DONE at the earliest.
- Bursts crossing a 4 KB boundary are the requester's responsibility; the bridge does not split them.

## Timing
- Reset values: all Valid/Ready, mem_* status, mem_rvalid, mem_wnext = 0; mem_dout = 0; Addr/Len = 0; state = IDLE; counter = 0.
- Request accepted at edge T; AR/AWValid high from T+1. Minimum read with 1 beat, zero-wait slave: AR T+1, R T+2, rvalid and done at T+3.
- Valid is held with stable payload until the Ready handshake (never withdrawn, except by rst).
- Ready during AR/AW and valid during R/B are ignored outside their states.
- rst mid-transfer: all outputs reach reset values at the next edge and the transaction is abandoned. The interconnect is reset with the bridge.
- mem_req while busy is ignored and not queued.

## Test plan
- Single read, len=0, addr 0x0000_0010, slave returns 0xDEADBEEF OKAY → ARLen=0, ARSize=2, one rvalid with dout=0xDEADBEEF, done with err=0 at T+3.
- Burst read, len=3, slave inserts 2 wait cycles before each beat → four rvalid pulses with data in order, RLast on beat 4, single done pulse.
- Burst write, len=1, bweb=0xFFFF_00FF → AW before W, WStrb=4'b0010, two mem_wnext pulses, WLast on beat 2, done after BValid.
- Write with BResp=2'b10 → done with err=1; next read completes with err=0.
- Misaligned addr 0x0000_0002 → no AR/AW; done with err=1 at T+1.
- rst asserted during W beat 2 of 4 → WValid=0 and busy=0 at next edge; a fresh read afterwards completes normally.
